// File: rtl/packet_retry_buffer.sv
// Packet retry buffer: FWFT FIFO with a rewindable retry window.
// Entries between mark_ptr and wr_ptr are protected until committed.
module packet_retry_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int OCC_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  store_tx_data,
    input  logic                  store_rx_packet_data,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [DATA_WIDTH-1:0] rx_packet_data,
    input  logic                  get_rx_data,
    input  logic                  get_tx_packet_data,
    input  logic                  clear,
    input  logic                  flush,
    input  logic                  pkt_mark,
    input  logic                  pkt_commit,
    input  logic                  pkt_rewind,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic [DATA_WIDTH-1:0] tx_packet_data,
    output logic [OCC_WIDTH-1:0]  buffer_occupancy,
    output logic [OCC_WIDTH-1:0]  retained_count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  collision
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [OCC_WIDTH-1:0]  r_wr_ptr;
    logic [OCC_WIDTH-1:0]  r_rd_ptr;
    logic [OCC_WIDTH-1:0]  r_mark_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_collision;

    logic [OCC_WIDTH-1:0]  w_occ;
    logic [OCC_WIDTH-1:0]  w_ret;
    logic [OCC_WIDTH-1:0]  w_wr_nxt;
    logic [OCC_WIDTH-1:0]  w_rd_nxt;
    logic [OCC_WIDTH-1:0]  w_mark_nxt;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_req;
    logic                  w_both;
    logic                  w_rd_req;
    logic                  w_ctl_clr;
    logic                  w_hold;
    logic                  w_rewind;
    logic                  w_commit;
    logic                  w_mark;
    logic                  w_wr_en;
    logic                  w_rd_en;

    assign w_occ   = r_wr_ptr - r_rd_ptr;
    assign w_ret   = r_wr_ptr - r_mark_ptr;
    assign w_full  = (w_ret == OCC_WIDTH'(DEPTH));
    assign w_empty = (w_occ == '0);

    assign w_wr_req  = store_tx_data | store_rx_packet_data;
    assign w_both    = store_tx_data & store_rx_packet_data;
    assign w_wr_data = store_tx_data ? tx_data : rx_packet_data;
    assign w_rd_req  = get_rx_data | get_tx_packet_data;
    assign w_ctl_clr = flush | clear;

    // Control priority: flush/clear > rewind > commit > mark
    assign w_rewind = !w_ctl_clr && pkt_rewind && w_hold;
    assign w_commit = !w_ctl_clr && !pkt_rewind && pkt_commit;
    assign w_mark   = !w_ctl_clr && !pkt_rewind && !pkt_commit && pkt_mark;

    // Full blocks writes even with a same-cycle pop, so the window stays intact
    assign w_wr_en = w_wr_req && !w_full && !w_ctl_clr;
    assign w_rd_en = w_rd_req && !w_empty && !w_rewind && !w_ctl_clr;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (1'b1)
            w_ctl_clr: w_state_nxt = S_IDLE;
            pkt_rewind: w_state_nxt = r_state;
            pkt_commit: w_state_nxt = S_IDLE;
            pkt_mark:   w_state_nxt = S_HOLD;
            default:    w_state_nxt = r_state;
        endcase
    end

    always_comb begin
        w_hold = (r_state == S_HOLD);
    end

    always_comb begin
        w_wr_nxt = r_wr_ptr;
        if (w_ctl_clr)    w_wr_nxt = '0;
        else if (w_wr_en) w_wr_nxt = r_wr_ptr + OCC_WIDTH'(1);
    end

    always_comb begin
        w_rd_nxt = r_rd_ptr;
        if (w_ctl_clr)     w_rd_nxt = '0;
        else if (w_rewind) w_rd_nxt = r_mark_ptr;
        else if (w_rd_en)  w_rd_nxt = r_rd_ptr + OCC_WIDTH'(1);
    end

    // Outside a window the mark trails the read pointer
    always_comb begin
        w_mark_nxt = w_rd_nxt;
        if (w_ctl_clr)                 w_mark_nxt = '0;
        else if (w_mark)               w_mark_nxt = r_rd_ptr;
        else if (w_hold && !w_commit)  w_mark_nxt = r_mark_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mark_ptr <= '0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_mark_ptr <= w_mark_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_collision <= 1'b0;
        end else if (!clear) begin
            if (w_both)
                r_collision <= 1'b1;
            if (w_wr_req && w_full)
                r_overflow <= 1'b1;
            if (w_rd_req && w_empty && !w_rewind)
                r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_en)
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
    end

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    assign rx_data          = w_empty ? '0 : w_head;
    assign tx_packet_data   = w_empty ? '0 : w_head;
    assign buffer_occupancy = w_occ;
    assign retained_count   = w_ret;
    assign full             = w_full;
    assign empty            = w_empty;
    assign overflow         = r_overflow;
    assign underflow        = r_underflow;
    assign collision        = r_collision;

endmodule

// File: tb/tb_packet_retry_buffer.sv
// Scoreboard bench for packet_retry_buffer: a queue-based window model
// predicts every cycle's outputs; a monitor compares after each edge.
module tb_packet_retry_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          store_tx_data, store_rx_packet_data;
    logic [DW-1:0] tx_data, rx_packet_data;
    logic          get_rx_data, get_tx_packet_data;
    logic          clear, flush;
    logic          pkt_mark, pkt_commit, pkt_rewind;
    logic [DW-1:0] rx_data, tx_packet_data;
    logic [OW-1:0] buffer_occupancy, retained_count;
    logic          full, empty, overflow, underflow, collision;

    packet_retry_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .store_tx_data(store_tx_data),
        .store_rx_packet_data(store_rx_packet_data),
        .tx_data(tx_data), .rx_packet_data(rx_packet_data),
        .get_rx_data(get_rx_data),
        .get_tx_packet_data(get_tx_packet_data),
        .clear(clear), .flush(flush),
        .pkt_mark(pkt_mark), .pkt_commit(pkt_commit),
        .pkt_rewind(pkt_rewind),
        .rx_data(rx_data), .tx_packet_data(tx_packet_data),
        .buffer_occupancy(buffer_occupancy),
        .retained_count(retained_count),
        .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow),
        .collision(collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          tx, rx;
        logic [DW-1:0] txd, rxd;
        logic          grx, gtx, clr, fl, mk, cm, rw, rs;
    } stim_t;

    typedef struct packed {
        logic [OW-1:0] occ, ret;
        logic          full, empty, ovf, unf, col;
        logic [DW-1:0] data;
    } exp_t;

    int n_chk  = 0;
    int n_pass = 0;
    exp_t sb[$];

    // Reference model: retained entries from the mark onwards, read offset
    logic [DW-1:0] mq[$];
    int rdoff = 0;
    bit hold = 0, m_ovf = 0, m_unf = 0, m_col = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(stim_t s);
        int pre, occ;
        bit rdq;
        if (s.rs || s.fl || s.clr) begin
            mq.delete();
            rdoff = 0;
            hold  = 0;
            if (s.rs || s.fl) begin
                m_ovf = 0; m_unf = 0; m_col = 0;
            end
            return;
        end
        pre = rdoff;
        occ = mq.size() - rdoff;
        rdq = s.grx | s.gtx;
        if (s.tx && s.rx) m_col = 1;
        if (s.tx || s.rx) begin
            if (mq.size() == DEPTH) m_ovf = 1;
            else mq.push_back(s.tx ? s.txd : s.rxd);
        end
        if (rdq && !(s.rw && hold)) begin
            if (occ == 0) m_unf = 1;
            else rdoff++;
        end
        if (s.rw) begin
            if (hold) rdoff = 0;
        end else if (s.cm) begin
            hold = 0;
        end else if (s.mk) begin
            for (int k = 0; k < pre; k++) void'(mq.pop_front());
            rdoff -= pre;
            hold = 1;
        end
        if (!hold) begin
            for (int k = 0; k < rdoff; k++) void'(mq.pop_front());
            rdoff = 0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int occ;
        occ     = mq.size() - rdoff;
        e.occ   = OW'(occ);
        e.ret   = OW'(mq.size());
        e.full  = (mq.size() == DEPTH);
        e.empty = (occ == 0);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.col   = m_col;
        e.data  = (occ == 0) ? '0 : mq[rdoff];
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic drive(stim_t s);
        @(negedge clk);
        store_tx_data        = s.tx;
        store_rx_packet_data = s.rx;
        tx_data              = s.txd;
        rx_packet_data       = s.rxd;
        get_rx_data          = s.grx;
        get_tx_packet_data   = s.gtx;
        clear                = s.clr;
        flush                = s.fl;
        pkt_mark             = s.mk;
        pkt_commit           = s.cm;
        pkt_rewind           = s.rw;
        rst                  = s.rs;
        model_step(s);
        sb.push_back(model_out());
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("occ",   32'(buffer_occupancy), 32'(e.occ));
            chk("ret",   32'(retained_count),   32'(e.ret));
            chk("full",  32'(full),             32'(e.full));
            chk("empty", 32'(empty),            32'(e.empty));
            chk("ovf",   32'(overflow),         32'(e.ovf));
            chk("unf",   32'(underflow),        32'(e.unf));
            chk("col",   32'(collision),        32'(e.col));
            chk("rxd",   32'(rx_data),          32'(e.data));
            chk("txpd",  32'(tx_packet_data),   32'(e.data));
        end
    end

    initial begin
        stim_t s;
        int wp, c;
        {store_tx_data, store_rx_packet_data, get_rx_data} = '0;
        {get_tx_packet_data, clear, flush} = '0;
        {pkt_mark, pkt_commit, pkt_rewind} = '0;
        tx_data = '0;
        rx_packet_data = '0;
        rst = 1'b1;

        s = idle(); s.rs = 1;
        drive(s); drive(s);
        settle();
        chk("rst_occ",   32'(buffer_occupancy), 0);
        chk("rst_empty", 32'(empty), 1);

        s = idle(); s.tx = 1; s.txd = 8'h01; drive(s);
        settle();
        chk("r35_head", 32'(rx_data), 32'h01);
        s = idle(); s.grx = 1; drive(s); drive(s);
        settle();
        chk("r35_unf", 32'(underflow), 1);

        s = idle(); s.fl = 1; drive(s);
        for (int i = 0; i < 65; i++) begin
            s = idle(); s.rx = 1; s.rxd = DW'(i); drive(s);
        end
        settle();
        chk("r36_full", 32'(full), 1);
        chk("r36_ovf",  32'(overflow), 1);
        for (int i = 0; i < 64; i++) begin
            s = idle(); s.gtx = 1; drive(s);
        end

        s = idle(); s.fl = 1; drive(s);
        s = idle(); s.tx = 1; s.rx = 1; s.txd = 8'hAA; s.rxd = 8'h55;
        drive(s);
        settle();
        chk("r37_data", 32'(rx_data), 32'hAA);
        chk("r37_col",  32'(collision), 1);
        chk("r37_occ",  32'(buffer_occupancy), 1);

        s = idle(); s.fl = 1; drive(s);
        for (int i = 0; i < 10; i++) begin
            s = idle(); s.tx = 1; s.txd = DW'(8'h10 + i); drive(s);
        end
        s = idle(); s.mk = 1; drive(s);
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.grx = 1; drive(s);
        end
        s = idle(); s.rw = 1; drive(s);
        settle();
        chk("r38_occ",  32'(buffer_occupancy), 10);
        chk("r38_ret",  32'(retained_count), 10);
        chk("r38_head", 32'(rx_data), 32'h10);
        s = idle(); s.cm = 1; drive(s);

        s = idle(); s.fl = 1; drive(s);
        for (int i = 0; i < 64; i++) begin
            s = idle(); s.tx = 1; s.txd = DW'($urandom); drive(s);
        end
        s = idle(); s.mk = 1; drive(s);
        for (int i = 0; i < 64; i++) begin
            s = idle(); s.grx = 1; drive(s);
        end
        s = idle(); s.tx = 1; s.txd = 8'h77; drive(s);
        settle();
        chk("r39_ovf", 32'(overflow), 1);
        s = idle(); s.cm = 1; drive(s);
        s = idle(); s.tx = 1; s.txd = 8'h78; drive(s);
        settle();
        chk("r39_occ",  32'(buffer_occupancy), 1);
        chk("r39_head", 32'(rx_data), 32'h78);

        s = idle(); s.fl = 1; drive(s);
        s = idle(); s.gtx = 1; drive(s);
        s = idle(); s.tx = 1; s.rx = 1; s.txd = 8'h01; drive(s);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.rx = 1; s.rxd = DW'(i); drive(s);
        end
        s = idle(); s.clr = 1; drive(s);
        settle();
        chk("r40_clr_occ", 32'(buffer_occupancy), 0);
        chk("r40_clr_unf", 32'(underflow), 1);
        chk("r40_clr_col", 32'(collision), 1);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.tx = 1; s.txd = DW'(i); drive(s);
        end
        s = idle(); s.fl = 1; drive(s);
        settle();
        chk("r40_fl_occ", 32'(buffer_occupancy), 0);
        chk("r40_fl_flg", 32'({overflow, underflow, collision}), 0);

        s = idle(); s.tx = 1; s.txd = 8'h33; drive(s);
        s = idle(); s.mk = 1; s.tx = 1; s.txd = 8'h34; drive(s);
        s = idle(); s.rs = 1; drive(s);
        settle();
        chk("rst_hold_ret", 32'(retained_count), 0);

        for (int i = 0; i < 4000; i++) begin
            wp = (i / 250) % 3 == 0 ? 85 : ((i / 250) % 3 == 1 ? 50 : 20);
            s = idle();
            s.tx  = ($urandom % 100) < wp;
            s.rx  = ($urandom % 100) < wp / 2;
            s.txd = DW'($urandom);
            s.rxd = DW'($urandom);
            s.grx = ($urandom % 100) < (100 - wp) / 2;
            s.gtx = ($urandom % 100) < (100 - wp) / 2;
            c = $urandom % 200;
            if (c < 6) s.mk = 1;
            else if (c < 10) s.cm = 1;
            else if (c < 16) s.rw = 1;
            else if (c == 16) s.clr = 1;
            else if (c == 17) s.fl = 1;
            else if (c == 18) s.rs = 1;
            drive(s);
        end

        s = idle(); drive(s);
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
